song_sequencer: RTL and testbench
=================================

SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 SHALL have parameter GAP_TICKS, default 10, meaning silent ticks inserted after every note.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning song ROM address width (256 entries).
REQ-003 SHALL have port clk, input, 1, meaning the single system clock (100 MHz).
REQ-004 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port tick, input, 1, meaning one-cycle 1 ms enable pulse from the clock divider.
REQ-006 SHALL have port start, input, 1, meaning one-cycle pulse that begins playback from address 0.
REQ-007 SHALL have port pause, input, 1, meaning one-cycle pulse that toggles pause/resume.
REQ-008 SHALL have port stop, input, 1, meaning one-cycle pulse that aborts playback.
REQ-009 SHALL have port tempo, input, 2, meaning ticks-per-unit select: 0=50, 1=75, 2=100, 3=125.
REQ-010 SHALL have port rom_addr, output, ADDR_W, meaning registered song ROM address.
REQ-011 SHALL have port rom_data, input, 13, meaning ROM word [12:8]=note code, [7:0]=duration in units; valid one cycle after rom_addr.
REQ-012 SHALL have port note, output, 5, meaning current note code to the tone generator.
REQ-013 SHALL have port note_valid, output, 1, meaning tone generator enabled.
REQ-014 SHALL have port busy, output, 1, meaning state is not IDLE.
REQ-015 SHALL have port done, output, 1, meaning one-cycle pulse when the song ends normally.

Function
REQ-016 SHALL implement states IDLE, FETCH, WAIT_ROM, PLAY, GAP, PAUSED.
REQ-017 IDLE + start SHALL set rom_addr=0 and go to FETCH; FETCH SHALL go unconditionally to WAIT_ROM.
REQ-018 WAIT_ROM SHALL sample rom_data and latch tempo; duration==0 (end marker) -> done pulse, IDLE; else latch note, go to PLAY.
REQ-019 note_valid SHALL rise exactly 3 cycles after the start pulse cycle; note code 0 (rest) SHALL keep note_valid low throughout that PLAY.
REQ-020 PLAY SHALL last exactly duration x ticks-per-unit tick pulses, then note_valid low and go to GAP.
REQ-021 GAP SHALL last exactly GAP_TICKS tick pulses, then rom_addr+1 and FETCH; if rom_addr==2^ADDR_W-1, done pulse and IDLE (no wrap).
REQ-022 tick pulses during IDLE, FETCH, WAIT_ROM, PAUSED SHALL be ignored.
REQ-023 pause in PLAY or GAP SHALL go to PAUSED, freezing all counters, forcing note_valid low; pause in PAUSED SHALL return to the frozen state with note_valid restored; pause elsewhere ignored.
REQ-024 stop in any non-IDLE state SHALL go to IDLE next cycle: note_valid=0, note=0, rom_addr=0, no done pulse.
REQ-025 Simultaneous inputs priority: stop > start > pause; start while busy SHALL be ignored.
REQ-026 tempo changes SHALL take effect only at the next WAIT_ROM.
REQ-027 Tick counter SHALL be 7 bits, unit counter 8 bits; no overflow possible for legal inputs.

Reset
REQ-028 reset SHALL force state IDLE, rom_addr=0, note=0, note_valid=0, busy=0, done=0, all counters 0, regardless of clk.
REQ-029 reset asserted mid-note SHALL silence note_valid immediately (asynchronously).

Structure
REQ-030 Shared package piano_pkg SHALL hold state encoding, tempo table (50/75/100/125), END_MARK (duration 0), REST_NOTE (0).
REQ-031 One sub-module beat_timer SHALL implement the tick/unit down-counters with load, enable and expire outputs.

Verification
REQ-032 ROM {C,2},{0,0}, tempo=0, start -> note_valid high at start+3, high for 100 ticks, low 10 ticks, done pulse once, busy low.
REQ-033 ROM {E,1},{rest,1},{G,1},{0,0}, tempo=2 -> E 100 ticks, gap, note_valid low 110 ticks, G 100 ticks, done.
REQ-034 pause at tick 40 of a 100-tick note, wait 500 ticks, pause -> note_valid resumes for exactly 60 more ticks.
REQ-035 stop and start same cycle mid-song -> IDLE, rom_addr=0, no done; start ignored.
REQ-036 Reset asserted mid-PLAY without clock edge -> note_valid=0 at once; all 256 entries nonzero duration -> done after address 255, no wrap.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared definitions for the song sequencer: FSM state encoding,
// ROM word markers and the tempo (ticks-per-unit) table.
package piano_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_ROM,
        PLAY,
        GAP,
        PAUSED
    } state_t;

    localparam int TICK_W = 7;
    localparam int UNIT_W = 8;
    localparam int NOTE_W = 5;

    localparam logic [UNIT_W-1:0] END_MARK  = 8'd0;
    localparam logic [NOTE_W-1:0] REST_NOTE = 5'd0;

    localparam logic [TICK_W-1:0] TPU_0 = 7'd50;
    localparam logic [TICK_W-1:0] TPU_1 = 7'd75;
    localparam logic [TICK_W-1:0] TPU_2 = 7'd100;
    localparam logic [TICK_W-1:0] TPU_3 = 7'd125;

    function automatic logic [TICK_W-1:0] tempo_tpu(input logic [1:0] sel);
        logic [TICK_W-1:0] v;
        case (sel)
            2'd0:    v = TPU_0;
            2'd1:    v = TPU_1;
            2'd2:    v = TPU_2;
            default: v = TPU_3;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/beat_timer.sv
// Two-level down-counter: ticks within a unit, units within a note.
// Expire fires on the enabled tick that completes the last unit.
module beat_timer
    import piano_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [TICK_W-1:0] i_tpu,
    input  logic [UNIT_W-1:0] i_units,
    input  logic              i_en,
    output logic              o_expire
);

    logic [TICK_W-1:0] r_tpu;
    logic [TICK_W-1:0] r_tick;
    logic [UNIT_W-1:0] r_unit;

    assign o_expire = i_en && (r_tick == '0) && (r_unit == '0);

    // Load a new length, or count down one tick per enabled pulse
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tpu  <= '0;
            r_tick <= '0;
            r_unit <= '0;
        end else if (i_load) begin
            r_tpu  <= i_tpu;
            r_tick <= i_tpu - 7'd1;
            r_unit <= i_units - 8'd1;
        end else if (i_en) begin
            if (r_tick == '0) begin
                if (r_unit != '0) begin
                    r_unit <= r_unit - 8'd1;
                    r_tick <= r_tpu - 7'd1;
                end
            end else begin
                r_tick <= r_tick - 7'd1;
            end
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks the song ROM, plays each note for its
// duration, inserts a silent gap, supports pause/resume and stop.
module song_sequencer
    import piano_pkg::*;
#(
    parameter int GAP_TICKS = 10,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    input  logic [1:0]        tempo,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [12:0]       rom_data,
    output logic [NOTE_W-1:0] note,
    output logic              note_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [TICK_W-1:0] GAP_TPU  = TICK_W'(GAP_TICKS);

    state_t            r_state;
    state_t            w_state_nxt;
    state_t            r_resume;
    state_t            w_resume_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [NOTE_W-1:0] r_note;
    logic [NOTE_W-1:0] w_note_nxt;
    logic              r_done;
    logic              w_done_nxt;

    logic              w_load;
    logic [TICK_W-1:0] w_ld_tpu;
    logic [UNIT_W-1:0] w_ld_units;
    logic              w_en;
    logic              w_expire;
    logic [UNIT_W-1:0] w_dur;
    logic [NOTE_W-1:0] w_code;

    assign w_dur  = rom_data[7:0];
    assign w_code = rom_data[12:8];

    // Pause and stop win over a coincident tick, freezing the counters
    assign w_en = tick && !stop && !pause &&
                  ((r_state == PLAY) || (r_state == GAP));

    beat_timer u_timer (
        .i_clk    (clk),
        .i_rst    (reset),
        .i_load   (w_load),
        .i_tpu    (w_ld_tpu),
        .i_units  (w_ld_units),
        .i_en     (w_en),
        .o_expire (w_expire)
    );

    assign rom_addr   = r_addr;
    assign note       = r_note;
    assign note_valid = (r_state == PLAY) && (r_note != REST_NOTE);
    assign busy       = (r_state != IDLE);
    assign done       = r_done;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_resume <= IDLE;
            r_addr   <= '0;
            r_note   <= REST_NOTE;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_resume <= w_resume_nxt;
            r_addr   <= w_addr_nxt;
            r_note   <= w_note_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Next-state, ROM address, note latch and timer load decisions
    always_comb begin
        w_state_nxt  = r_state;
        w_resume_nxt = r_resume;
        w_addr_nxt   = r_addr;
        w_note_nxt   = r_note;
        w_done_nxt   = 1'b0;
        w_load       = 1'b0;
        w_ld_tpu     = GAP_TPU;
        w_ld_units   = 8'd1;
        if (stop && (r_state != IDLE)) begin
            w_state_nxt = IDLE;
            w_addr_nxt  = '0;
            w_note_nxt  = REST_NOTE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && !stop) begin
                        w_state_nxt = FETCH;
                        w_addr_nxt  = '0;
                    end
                end
                FETCH: begin
                    w_state_nxt = WAIT_ROM;
                end
                WAIT_ROM: begin
                    if (w_dur == END_MARK) begin
                        w_done_nxt  = 1'b1;
                        w_note_nxt  = REST_NOTE;
                        w_state_nxt = IDLE;
                    end else begin
                        w_note_nxt  = w_code;
                        w_load      = 1'b1;
                        w_ld_tpu    = tempo_tpu(tempo);
                        w_ld_units  = w_dur;
                        w_state_nxt = PLAY;
                    end
                end
                PLAY: begin
                    if (pause) begin
                        w_resume_nxt = PLAY;
                        w_state_nxt  = PAUSED;
                    end else if (w_expire) begin
                        w_load      = 1'b1;
                        w_state_nxt = GAP;
                    end
                end
                GAP: begin
                    if (pause) begin
                        w_resume_nxt = GAP;
                        w_state_nxt  = PAUSED;
                    end else if (w_expire) begin
                        if (r_addr == ADDR_MAX) begin
                            w_done_nxt  = 1'b1;
                            w_note_nxt  = REST_NOTE;
                            w_state_nxt = IDLE;
                        end else begin
                            w_addr_nxt  = r_addr + 1'b1;
                            w_state_nxt = FETCH;
                        end
                    end
                end
                PAUSED: begin
                    if (pause) begin
                        w_state_nxt = r_resume;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: stimulus pushes expected note
// events, a negedge monitor pops and compares as the DUT produces them.
module tb_song_sequencer;

    localparam int EV_LO   = 0;
    localparam int EV_ON   = 1;
    localparam int EV_HI   = 2;
    localparam int EV_DONE = 3;

    localparam logic [4:0] N_C = 5'd1;
    localparam logic [4:0] N_E = 5'd5;
    localparam logic [4:0] N_G = 5'd8;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic        clk;
    logic        reset;
    logic        tick;
    logic        start;
    logic        pause;
    logic        stop;
    logic [1:0]  tempo;
    logic [7:0]  rom_addr;
    logic [12:0] rom_data;
    logic [4:0]  note;
    logic        note_valid;
    logic        busy;
    logic        done;

    logic [12:0] mem [0:255];
    ev_t         exp_q[$];
    int          n_checks;
    int          n_errors;
    int          cyc;
    int          ev_idx;

    song_sequencer #(
        .GAP_TICKS (10),
        .ADDR_W    (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .start      (start),
        .pause      (pause),
        .stop       (stop),
        .tempo      (tempo),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .note       (note),
        .note_valid (note_valid),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous song ROM: data follows the address by one cycle
    always @(posedge clk) rom_data <= mem[rom_addr];

    function automatic string kn(input int k);
        case (k)
            EV_LO:   return "low_ticks";
            EV_ON:   return "note_on";
            EV_HI:   return "high_ticks";
            default: return "done";
        endcase
    endfunction

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic push(input int k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input int k, input int v);
        ev_t e;
        n_checks++;
        ev_idx++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL ev%0d unexpected: got %s=%0d want nothing",
                     ev_idx, kn(k), v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                n_errors++;
                $display("FAIL ev%0d: got %s=%0d want %s=%0d",
                         ev_idx, kn(k), v, kn(e.kind), e.val);
            end
        end
    endtask

    // Monitor: measures high/low tick spans and done pulses
    initial begin
        logic prev;
        int   hi;
        int   lo;
        prev = 1'b0;
        hi   = 0;
        lo   = 0;
        forever begin
            @(negedge clk);
            if (note_valid && !prev) begin
                got_ev(EV_LO, lo);
                got_ev(EV_ON, int'(note));
                hi = 0;
                lo = 0;
            end
            if (!note_valid && prev) begin
                got_ev(EV_HI, hi);
                lo = 0;
            end
            if (done) got_ev(EV_DONE, lo);
            if (tick && note_valid) hi++;
            if (tick && busy && !note_valid) lo++;
            if (!busy) lo = 0;
            prev = note_valid;
        end
    end

    // One cycle; pulses clear, tick every third cycle
    task automatic step();
        @(posedge clk);
        #1;
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
        cyc++;
        tick = (cyc % 3 == 0);
    endtask

    task automatic align();
        while (!tick) step();
    endtask

    task automatic wait_idle(input string name, input int max);
        int k;
        k = 0;
        while (busy && k < max) begin
            step();
            k++;
        end
        chk(name, int'(busy), 0);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) mem[i] = 13'd0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        ev_idx   = 0;
        reset    = 1'b1;
        tick     = 1'b0;
        start    = 1'b0;
        pause    = 1'b0;
        stop     = 1'b0;
        tempo    = 2'd0;
        clear_rom();
        repeat (3) step();
        chk("rst_addr", int'(rom_addr), 0);
        chk("rst_note", int'(note), 0);
        chk("rst_nv", int'(note_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;
        repeat (2) step();

        // Single note then end marker, tempo 50
        clear_rom();
        mem[0] = {N_C, 8'd2};
        tempo  = 2'd0;
        push(EV_LO, 0); push(EV_ON, N_C);
        push(EV_HI, 100); push(EV_DONE, 10);
        align();
        start = 1'b1;
        step();
        chk("t1_nv_c1", int'(note_valid), 0);
        chk("t1_busy_c1", int'(busy), 1);
        step();
        chk("t1_nv_c2", int'(note_valid), 0);
        step();
        chk("t1_nv_c3", int'(note_valid), 1);
        wait_idle("t1_end", 2000);
        step();
        chk("t1_busy", int'(busy), 0);
        chk("t1_queue", exp_q.size(), 0);

        // Note, rest, note, tempo 100
        clear_rom();
        mem[0] = {N_E, 8'd1};
        mem[1] = {5'd0, 8'd1};
        mem[2] = {N_G, 8'd1};
        tempo  = 2'd2;
        push(EV_LO, 0); push(EV_ON, N_E); push(EV_HI, 100);
        push(EV_LO, 10 + 100 + 10); push(EV_ON, N_G);
        push(EV_HI, 100); push(EV_DONE, 10);
        align();
        start = 1'b1;
        step();
        wait_idle("t2_end", 3000);
        step();
        chk("t2_queue", exp_q.size(), 0);

        // Pause after 40 of 100 ticks, 500 ticks paused, tempo change
        clear_rom();
        mem[0] = {N_C, 8'd1};
        tempo  = 2'd2;
        push(EV_LO, 0); push(EV_ON, N_C); push(EV_HI, 40);
        push(EV_LO, 500); push(EV_ON, N_C); push(EV_HI, 60);
        push(EV_DONE, 10);
        align();
        start = 1'b1;
        step();
        repeat (120) step();
        pause = 1'b1;
        step();
        chk("t3_paused_nv", int'(note_valid), 0);
        chk("t3_paused_busy", int'(busy), 1);
        tempo = 2'd3;
        repeat (1500) step();
        pause = 1'b1;
        step();
        chk("t3_resumed_nv", int'(note_valid), 1);
        chk("t3_resumed_note", int'(note), int'(N_C));
        wait_idle("t3_end", 1000);
        step();
        chk("t3_queue", exp_q.size(), 0);

        // Stop and start together mid-note
        clear_rom();
        mem[0] = {N_C, 8'd2};
        tempo  = 2'd0;
        push(EV_LO, 0); push(EV_ON, N_C); push(EV_HI, 30);
        align();
        start = 1'b1;
        step();
        repeat (90) step();
        stop  = 1'b1;
        start = 1'b1;
        step();
        chk("t4_busy", int'(busy), 0);
        chk("t4_nv", int'(note_valid), 0);
        chk("t4_note", int'(note), 0);
        chk("t4_addr", int'(rom_addr), 0);
        repeat (6) step();
        chk("t4_busy_later", int'(busy), 0);
        chk("t4_queue", exp_q.size(), 0);

        // Asynchronous reset in the middle of a note
        push(EV_LO, 0); push(EV_ON, N_C); push(EV_HI, 7);
        align();
        start = 1'b1;
        step();
        repeat (21) step();
        chk("t5_nv_before", int'(note_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_nv", int'(note_valid), 0);
        chk("t5_note", int'(note), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_done", int'(done), 0);
        repeat (2) step();
        reset = 1'b0;
        repeat (2) step();
        chk("t5_queue", exp_q.size(), 0);

        // Every entry non-empty: end after the last address, no wrap
        for (int i = 0; i < 256; i++) mem[i] = {5'd3, 8'd1};
        tempo = 2'd0;
        push(EV_LO, 0); push(EV_ON, 3); push(EV_HI, 50);
        for (int i = 1; i < 256; i++) begin
            push(EV_LO, 10); push(EV_ON, 3); push(EV_HI, 50);
        end
        push(EV_DONE, 10);
        align();
        start = 1'b1;
        step();
        wait_idle("t6_end", 50000);
        chk("t6_addr_end", int'(rom_addr), 255);
        repeat (2) step();
        chk("t6_busy", int'(busy), 0);
        chk("t6_addr_hold", int'(rom_addr), 255);
        chk("t6_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
